apb_gpio_v2: RTL and testbench

Next-generation APB GPIO slave, parametrised to 1..32 pins. Each pin has its own configuration register, a 2-FF input synchroniser, an optional per-pin debounce filter and five interrupt modes with write-1-to-clear pending bits. Atomic set/clear/toggle output registers remove read-modify-write races. The block sits on the peripheral APB bus beside the existing GPIO core and drives pad buffers and the interrupt controller.

---
 rtl/apb_gpio_v2_pkg.sv | 32 +++
 rtl/apb_gpio_v2_if.sv | 21 ++
 rtl/apb_gpio_v2_pin.sv | 87 ++++++++
 rtl/apb_gpio_v2.sv | 140 ++++++++++++++
 tb/tb_apb_gpio_v2.sv | 369 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/apb_gpio_v2_pkg.sv
// Shared constants and types for the APB GPIO v2 block: register offsets,
// CONFIG field positions and the interrupt-type encoding.
package apb_gpio_v2_pkg;

  localparam int unsigned DB_W_DEFAULT = 8;

  localparam logic [7:0] ADDR_IRQ = 8'h80;
  localparam logic [7:0] ADDR_IN  = 8'h90;
  localparam logic [7:0] ADDR_OUT = 8'hA0;
  localparam logic [7:0] ADDR_SET = 8'hA4;
  localparam logic [7:0] ADDR_CLR = 8'hA8;
  localparam logic [7:0] ADDR_TGL = 8'hAC;
  localparam logic [7:0] ADDR_DBP = 8'hB0;

  localparam int CFG_OE       = 2;
  localparam int CFG_INT_EN   = 3;
  localparam int CFG_TYPE_LSB = 5;
  localparam int CFG_DB_EN    = 8;

  // Only OE, INT_EN, INT_TYPE and DB_EN are storable; other bits read 0.
  localparam logic [8:0] CFG_MASK = 9'h1EC;

  typedef enum logic [2:0] {
    INT_LVL_HIGH = 3'd0,
    INT_LVL_LOW  = 3'd1,
    INT_RISE     = 3'd2,
    INT_FALL     = 3'd3,
    INT_BOTH     = 3'd4,
    INT_NONE     = 3'd5
  } int_type_e;

endpackage

// File: rtl/apb_gpio_v2_if.sv
// APB slave bus bundle used by the GPIO block.
interface apb_gpio_v2_if;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [7:0]  PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_gpio_v2_pin.sv
// One GPIO pin: 2-FF synchroniser, debounce filter, edge/level event decode
// and the sticky interrupt pending flag.
module apb_gpio_v2_pin
  import apb_gpio_v2_pkg::*;
#(
  parameter int DB_W = DB_W_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            gpio_in,
  input  logic            db_en,
  input  logic [DB_W-1:0] db_period,
  input  logic            int_en,
  input  int_type_e       int_type,
  input  logic            clr,
  output logic            p,
  output logic            pend
);

  logic [1:0]      sync_q, sync_d;
  logic            filt_q, filt_d;
  logic [DB_W-1:0] cnt_q, cnt_d;
  logic            prev_q, prev_d;
  logic            pend_q, pend_d;
  logic            evt_s;

  assign p    = db_en ? filt_q : sync_q[1];
  assign pend = pend_q;

  // Next-state for synchroniser, debounce filter, previous value and pending.
  always_comb begin
    sync_d = {sync_q[0], gpio_in};
    filt_d = filt_q;
    cnt_d  = cnt_q;
    if (!db_en) begin
      // Track the input so enabling the filter later produces no edge.
      filt_d = sync_q[1];
      cnt_d  = {DB_W{1'b0}};
    end else if (sync_q[1] == filt_q) begin
      cnt_d = {DB_W{1'b0}};
    end else if (cnt_q == db_period) begin
      filt_d = sync_q[1];
      cnt_d  = {DB_W{1'b0}};
    end else begin
      cnt_d = cnt_q + {{(DB_W-1){1'b0}}, 1'b1};
    end

    prev_d = p;

    evt_s = 1'b0;
    case (int_type)
      INT_LVL_HIGH: evt_s = p;
      INT_LVL_LOW:  evt_s = ~p;
      INT_RISE:     evt_s = p & ~prev_q;
      INT_FALL:     evt_s = ~p & prev_q;
      INT_BOTH:     evt_s = p ^ prev_q;
      default:      evt_s = 1'b0;
    endcase

    // A new event beats a same-cycle write-1-to-clear.
    if (int_en && evt_s) begin
      pend_d = 1'b1;
    end else if (clr) begin
      pend_d = 1'b0;
    end else begin
      pend_d = pend_q;
    end
  end

  // Pin state registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b00;
      filt_q <= 1'b0;
      cnt_q  <= {DB_W{1'b0}};
      prev_q <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
      prev_q <= prev_d;
      pend_q <= pend_d;
    end
  end

endmodule

// File: rtl/apb_gpio_v2.sv
// APB GPIO v2 top: bus decode, CONFIG/OUT/DB_PERIOD registers, read mux
// and one pin instance per implemented GPIO.
module apb_gpio_v2
  import apb_gpio_v2_pkg::*;
#(
  parameter int                IO_NUM     = 32,
  parameter int                DB_W       = DB_W_DEFAULT,
  parameter int                DB_DEFAULT = 3,
  parameter logic [IO_NUM-1:0] OUT_RESET  = {IO_NUM{1'b0}}
) (
  input  logic              PCLK,
  input  logic              PRESETN,
  apb_gpio_v2_if.slave      apb,
  input  logic [IO_NUM-1:0] GPIO_IN,
  output logic [IO_NUM-1:0] GPIO_OUT,
  output logic [IO_NUM-1:0] GPIO_OE,
  output logic [IO_NUM-1:0] INT,
  output logic              INT_OR
);

  logic [8:0]        cfg_q [IO_NUM];
  logic [8:0]        cfg_d [IO_NUM];
  logic [IO_NUM-1:0] out_q, out_d;
  logic [DB_W-1:0]   dbp_q, dbp_d;

  logic [7:0]        addr_s;
  logic [4:0]        cfg_idx_s;
  logic              access_s, cfg_hit_s, reg_hit_s, err_s, wr_ok_s;
  logic [31:0]       prdata_s;
  logic [IO_NUM-1:0] p_s, pend_s, int_en_s, clr_s;
  logic              unused_s;

  assign addr_s    = {apb.PADDR[7:2], 2'b00};
  assign cfg_idx_s = addr_s[6:2];
  assign access_s  = apb.PSEL & apb.PENABLE;
  assign cfg_hit_s = (addr_s[7] == 1'b0) && ({27'd0, cfg_idx_s} < 32'(IO_NUM));
  assign err_s     = access_s & (~reg_hit_s | (apb.PWRITE & (addr_s == ADDR_IN)));
  assign wr_ok_s   = access_s & apb.PWRITE & ~err_s;
  assign clr_s     = (wr_ok_s && addr_s == ADDR_IRQ) ? apb.PWDATA[IO_NUM-1:0]
                                                     : {IO_NUM{1'b0}};
  assign unused_s  = ^{apb.PWDATA, apb.PADDR[1:0]};

  assign apb.PRDATA  = prdata_s;
  assign apb.PREADY  = 1'b1;
  assign apb.PSLVERR = err_s;
  assign GPIO_OUT    = out_q;
  assign INT         = pend_s & int_en_s;
  assign INT_OR      = |INT;

  // Address decode: which offsets are backed by a register.
  always_comb begin
    reg_hit_s = 1'b0;
    case (addr_s)
      ADDR_IRQ, ADDR_IN, ADDR_OUT, ADDR_SET,
      ADDR_CLR, ADDR_TGL, ADDR_DBP: reg_hit_s = 1'b1;
      default:                      reg_hit_s = cfg_hit_s;
    endcase
  end

  // Register write path, including atomic set/clear/toggle on OUT.
  always_comb begin
    cfg_d = cfg_q;
    out_d = out_q;
    dbp_d = dbp_q;
    if (wr_ok_s) begin
      for (int n = 0; n < IO_NUM; n++) begin
        if (cfg_hit_s && cfg_idx_s == 5'(n)) begin
          cfg_d[n] = apb.PWDATA[8:0] & CFG_MASK;
        end else begin
          cfg_d[n] = cfg_q[n];
        end
      end
      case (addr_s)
        ADDR_OUT: out_d = apb.PWDATA[IO_NUM-1:0];
        ADDR_SET: out_d = out_q | apb.PWDATA[IO_NUM-1:0];
        ADDR_CLR: out_d = out_q & ~apb.PWDATA[IO_NUM-1:0];
        ADDR_TGL: out_d = out_q ^ apb.PWDATA[IO_NUM-1:0];
        ADDR_DBP: dbp_d = apb.PWDATA[DB_W-1:0];
        default:  out_d = out_q;
      endcase
    end else begin
      out_d = out_q;
    end
  end

  // Read mux: data only during a read access phase, zero otherwise.
  always_comb begin
    prdata_s = 32'h0000_0000;
    if (access_s && !apb.PWRITE) begin
      for (int n = 0; n < IO_NUM; n++) begin
        if (cfg_hit_s && cfg_idx_s == 5'(n)) begin
          prdata_s[8:0] = cfg_q[n];
        end else begin
          prdata_s = prdata_s;
        end
      end
      case (addr_s)
        ADDR_IRQ: prdata_s[IO_NUM-1:0] = pend_s;
        ADDR_IN:  prdata_s[IO_NUM-1:0] = p_s;
        ADDR_OUT: prdata_s[IO_NUM-1:0] = out_q;
        ADDR_DBP: prdata_s[DB_W-1:0]   = dbp_q;
        default:  prdata_s = prdata_s;
      endcase
    end else begin
      prdata_s = 32'h0000_0000;
    end
  end

  // Configuration, output and debounce-period registers.
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      cfg_q <= '{default: 9'h000};
      out_q <= OUT_RESET;
      dbp_q <= DB_W'(DB_DEFAULT);
    end else begin
      cfg_q <= cfg_d;
      out_q <= out_d;
      dbp_q <= dbp_d;
    end
  end

  for (genvar g = 0; g < IO_NUM; g++) begin : g_pin
    assign GPIO_OE[g]  = cfg_q[g][CFG_OE];
    assign int_en_s[g] = cfg_q[g][CFG_INT_EN];

    apb_gpio_v2_pin #(.DB_W(DB_W)) u_pin (
      .clk       (PCLK),
      .rst_n     (PRESETN),
      .gpio_in   (GPIO_IN[g]),
      .db_en     (cfg_q[g][CFG_DB_EN]),
      .db_period (dbp_q),
      .int_en    (cfg_q[g][CFG_INT_EN]),
      .int_type  (int_type_e'(cfg_q[g][CFG_TYPE_LSB +: 3])),
      .clr       (clr_s[g]),
      .p         (p_s[g]),
      .pend      (pend_s[g])
    );
  end

endmodule

// File: tb/tb_apb_gpio_v2.sv
// Self-checking bench for apb_gpio_v2: a behavioural model of the register
// file and pin behaviour is compared against the 32-pin DUT on every falling
// edge; an 8-pin instance sharing the bus checks the narrow-build rules.
module tb_apb_gpio_v2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  apb_gpio_v2_if bus ();
  apb_gpio_v2_if bus8 ();
  assign bus8.PSEL    = bus.PSEL;
  assign bus8.PENABLE = bus.PENABLE;
  assign bus8.PWRITE  = bus.PWRITE;
  assign bus8.PADDR   = bus.PADDR;
  assign bus8.PWDATA  = bus.PWDATA;

  logic [31:0] gin = 32'h0;
  logic [31:0] gout, goe, gint;
  logic        gint_or;
  logic [7:0]  gout8, goe8, gint8;
  logic        gint_or8;

  apb_gpio_v2 #(.IO_NUM(32)) dut (
    .PCLK(clk), .PRESETN(rst_n), .apb(bus), .GPIO_IN(gin),
    .GPIO_OUT(gout), .GPIO_OE(goe), .INT(gint), .INT_OR(gint_or)
  );

  apb_gpio_v2 #(.IO_NUM(8)) dut8 (
    .PCLK(clk), .PRESETN(rst_n), .apb(bus8), .GPIO_IN(gin[7:0]),
    .GPIO_OUT(gout8), .GPIO_OE(goe8), .INT(gint8), .INT_OR(gint_or8)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model state (32-pin instance).
  logic [8:0]  m_cfg [32];
  logic [31:0] m_out, m_pend, m_s1, m_s2, m_filt, m_prev;
  logic [7:0]  m_dbp;
  int          m_run [32];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] cfg_bits(input int b);
    logic [31:0] v;
    for (int i = 0; i < 32; i++) v[i] = m_cfg[i][b];
    return v;
  endfunction

  function automatic logic [31:0] m_p();
    logic [31:0] d;
    d = cfg_bits(8);
    return (m_filt & d) | (m_s2 & ~d);
  endfunction

  function automatic logic [7:0] cur_addr();
    return {bus.PADDR[7:2], 2'b00};
  endfunction

  function automatic bit is_reg(input logic [7:0] a);
    return (a < 8'h80) || a == 8'h80 || a == 8'h90 || a == 8'hA0 || a == 8'hA4 ||
           a == 8'hA8 || a == 8'hAC || a == 8'hB0;
  endfunction

  function automatic logic m_err();
    logic [7:0] a;
    a = cur_addr();
    if (!(bus.PSEL && bus.PENABLE)) return 1'b0;
    return !is_reg(a) || (bus.PWRITE && a == 8'h90);
  endfunction

  function automatic logic [31:0] m_rd();
    logic [7:0] a;
    a = cur_addr();
    if (!(bus.PSEL && bus.PENABLE && !bus.PWRITE)) return 32'h0;
    if (a < 8'h80) return {23'h0, m_cfg[a[6:2]]};
    case (a)
      8'h80:   return m_pend;
      8'h90:   return m_p();
      8'hA0:   return m_out;
      8'hB0:   return {24'h0, m_dbp};
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_cfg[i] = 9'h0;
      m_run[i] = 0;
    end
    m_out = 32'h0; m_pend = 32'h0; m_s1 = 32'h0; m_s2 = 32'h0;
    m_filt = 32'h0; m_prev = 32'h0; m_dbp = 8'd3;
  endtask

  // Advance the model by one clock using the inputs present at the edge.
  task automatic model_step();
    logic [31:0] p, evt, w1c, wd, dben;
    logic [7:0]  a;
    bit          wr;
    p   = m_p();
    wd  = bus.PWDATA;
    a   = cur_addr();
    wr  = bus.PSEL && bus.PENABLE && bus.PWRITE && !m_err();
    w1c = (wr && a == 8'h80) ? wd : 32'h0;
    for (int i = 0; i < 32; i++) begin
      case (m_cfg[i][7:5])
        3'd0:    evt[i] = p[i];
        3'd1:    evt[i] = !p[i];
        3'd2:    evt[i] = p[i] && !m_prev[i];
        3'd3:    evt[i] = !p[i] && m_prev[i];
        3'd4:    evt[i] = p[i] != m_prev[i];
        default: evt[i] = 1'b0;
      endcase
    end
    m_pend = (m_pend & ~w1c) | (evt & cfg_bits(3));
    // Filter: accept a new level once it has disagreed for DB_PERIOD+1 edges.
    dben = cfg_bits(8);
    for (int i = 0; i < 32; i++) begin
      if (!dben[i] || m_s2[i] == m_filt[i]) begin
        if (!dben[i]) m_filt[i] = m_s2[i];
        m_run[i] = 0;
      end else if (m_run[i] == int'(m_dbp)) begin
        m_filt[i] = m_s2[i];
        m_run[i] = 0;
      end else begin
        m_run[i]++;
      end
    end
    m_prev = p;
    m_s2 = m_s1;
    m_s1 = gin;
    if (wr) begin
      if (a < 8'h80) m_cfg[a[6:2]] = wd[8:0] & 9'h1EC;
      else begin
        case (a)
          8'hA0:   m_out = wd;
          8'hA4:   m_out = m_out | wd;
          8'hA8:   m_out = m_out & ~wd;
          8'hAC:   m_out = m_out ^ wd;
          8'hB0:   m_dbp = wd[7:0];
          default: ;
        endcase
      end
    end
  endtask

  // Every-cycle comparison of the 32-pin DUT against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      check("GPIO_OUT", gout, m_out);
      check("GPIO_OE", goe, cfg_bits(2));
      check("INT", gint, m_pend & cfg_bits(3));
      check("INT_OR", {31'h0, gint_or}, {31'h0, |(m_pend & cfg_bits(3))});
      check("PRDATA", bus.PRDATA, m_rd());
      check("PSLVERR", {31'h0, bus.PSLVERR}, {31'h0, m_err()});
      check("PREADY", {31'h0, bus.PREADY}, 32'h1);
    end
  end

  task automatic cyc();
    @(posedge clk);
    if (rst_n) model_step();
    else model_reset();
    #1;
  endtask

  task automatic bus_idle();
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
  endtask

  task automatic apb_wr(input logic [7:0] a, input logic [31:0] d);
    bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b1;
    bus.PADDR = a; bus.PWDATA = d;
    cyc();
    bus.PENABLE = 1'b1;
    cyc();
    bus_idle();
  endtask

  task automatic apb_rd_nc(input logic [7:0] a);
    bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0; bus.PADDR = a;
    cyc();
    bus.PENABLE = 1'b1;
    cyc();
    bus_idle();
  endtask

  task automatic apb_rd(input logic [7:0] a, input logic [31:0] exp_d,
                        input logic exp_e, input string name);
    bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0; bus.PADDR = a;
    cyc();
    bus.PENABLE = 1'b1;
    @(negedge clk);
    check(name, bus.PRDATA, exp_d);
    check({name, "_err"}, {31'h0, bus.PSLVERR}, {31'h0, exp_e});
    cyc();
    bus_idle();
  endtask

  task automatic apb_rd8(input logic [7:0] a, input logic [31:0] exp_d,
                         input logic exp_e, input string name);
    bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0; bus.PADDR = a;
    cyc();
    bus.PENABLE = 1'b1;
    @(negedge clk);
    check(name, bus8.PRDATA, exp_d);
    check({name, "_err"}, {31'h0, bus8.PSLVERR}, {31'h0, exp_e});
    cyc();
    bus_idle();
  endtask

  // Pulse GPIO_IN[1] high while continuously reading IN; report if IN[1] rose.
  task automatic pulse_in1(input int hi, output bit seen);
    seen = 1'b0;
    bus.PSEL = 1'b1; bus.PENABLE = 1'b1; bus.PWRITE = 1'b0; bus.PADDR = 8'h90;
    gin[1] = 1'b1;
    for (int i = 0; i < hi; i++) begin
      @(negedge clk);
      seen = seen | bus.PRDATA[1];
      cyc();
    end
    gin[1] = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      seen = seen | bus.PRDATA[1];
      cyc();
    end
    bus_idle();
  endtask

  function automatic logic [7:0] rand_addr();
    logic [7:0] a;
    case ($urandom_range(0, 9))
      0, 1, 2, 3: a = {1'b0, 5'($urandom_range(0, 31)), 2'b00};
      4:          a = 8'h80;
      5:          a = 8'h90;
      6:          a = 8'hA0 + 8'(4 * $urandom_range(0, 3));
      7:          a = 8'hB0;
      8:          a = 8'h84;
      default:    a = 8'($urandom_range(0, 255));
    endcase
    return a | 8'($urandom_range(0, 3));
  endfunction

  bit seen;

  initial begin
    bus_idle();
    bus.PADDR = 8'h0; bus.PWDATA = 32'h0;
    model_reset();

    // Reset state.
    repeat (2) cyc();
    @(negedge clk);
    check("rst GPIO_OUT", gout, 32'h0);
    check("rst GPIO_OE", goe, 32'h0);
    check("rst INT", gint, 32'h0);
    check("rst INT_OR", {31'h0, gint_or}, 32'h0);
    check("rst PSLVERR", {31'h0, bus.PSLVERR}, 32'h0);
    cyc();
    rst_n = 1'b1;
    cyc();

    apb_rd(8'h00, 32'h0, 1'b0, "CONFIG_0");
    apb_rd(8'h7C, 32'h0, 1'b0, "CONFIG_31");
    apb_rd(8'hA0, 32'h0, 1'b0, "OUT rst");
    apb_rd(8'hB0, 32'h3, 1'b0, "DB_PERIOD rst");
    apb_rd(8'h80, 32'h0, 1'b0, "IRQ rst");
    apb_rd(8'hC0, 32'h0, 1'b1, "unmapped C0");

    // Atomic output updates.
    apb_wr(8'hA0, 32'h0000_00F0); check("OUT wr", gout, 32'h0000_00F0);
    apb_wr(8'hA4, 32'h0000_0003); check("OUT set", gout, 32'h0000_00F3);
    apb_wr(8'hA8, 32'h0000_0010); check("OUT clr", gout, 32'h0000_00E3);
    apb_wr(8'hAC, 32'h0000_0081); check("OUT tgl", gout, 32'h0000_0062);
    apb_rd(8'hA0, 32'h0000_0062, 1'b0, "OUT rd");
    apb_rd(8'hA4, 32'h0, 1'b0, "SET rd");

    // Rising-edge interrupt on pin 4.
    apb_wr(8'h10, 32'h0000_0048);
    gin[4] = 1'b1;
    repeat (4) cyc();
    apb_rd(8'h80, 32'h0000_0010, 1'b0, "IRQ4 set");
    check("INT4", gint, 32'h0000_0010);
    check("INT_OR4", {31'h0, gint_or}, 32'h1);
    apb_wr(8'h80, 32'h0000_0010);
    apb_rd(8'h80, 32'h0, 1'b0, "IRQ4 w1c");
    gin[4] = 1'b0;
    repeat (4) cyc();
    gin[4] = 1'b1;
    cyc();
    apb_wr(8'h80, 32'h0000_0010);
    apb_rd(8'h80, 32'h0000_0010, 1'b0, "IRQ4 set wins");
    apb_wr(8'h80, 32'h0000_0010);

    // Level-high interrupt on pin 0 re-pends; masking keeps pending.
    apb_wr(8'h00, 32'h0000_0008);
    gin[0] = 1'b1;
    repeat (4) cyc();
    apb_wr(8'h80, 32'h0000_0001);
    apb_rd(8'h80, 32'h0000_0001, 1'b0, "IRQ0 repend");
    apb_wr(8'h00, 32'h0000_0000);
    cyc();
    check("INT0 masked", gint, 32'h0);
    apb_rd(8'h80, 32'h0000_0001, 1'b0, "IRQ0 kept");
    apb_wr(8'h80, 32'h0000_0001);

    // Debounce on pin 1 with DB_PERIOD=3.
    apb_wr(8'h04, 32'h0000_0100);
    apb_wr(8'hB0, 32'h0000_0003);
    repeat (3) cyc();
    pulse_in1(3, seen);
    check("DB short pulse", {31'h0, seen}, 32'h0);
    pulse_in1(6, seen);
    check("DB long pulse", {31'h0, seen}, 32'h1);

    // Narrow 8-pin build.
    apb_wr(8'hA0, 32'hFFFF_FFFF);
    check("OUT8 pins", {24'h0, gout8}, 32'h0000_00FF);
    apb_rd8(8'hA0, 32'h0000_00FF, 1'b0, "OUT8 rd");
    apb_wr(8'h20, 32'h0000_0004);
    check("OE8 ignored", {24'h0, goe8}, 32'h0);
    apb_rd8(8'h20, 32'h0, 1'b1, "CONFIG_8 err");

    // Reset during a write access phase aborts it.
    bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b1;
    bus.PADDR = 8'hA0; bus.PWDATA = 32'h1234_5678;
    cyc();
    bus.PENABLE = 1'b1;
    #2 rst_n = 1'b0;
    #1 check("mid-reset OUT", gout, 32'h0);
    bus_idle();
    repeat (2) cyc();
    rst_n = 1'b1;
    cyc();
    apb_rd(8'hA0, 32'h0, 1'b0, "OUT after reset");

    // Randomised traffic against the model.
    for (int it = 0; it < 1500; it++) begin
      logic [7:0] a;
      logic [31:0] d;
      if ($urandom_range(0, 2) == 0) begin
        int k;
        k = $urandom_range(0, 31);
        gin[k] = ~gin[k];
      end
      a = rand_addr();
      d = $urandom;
      if ({a[7:2], 2'b00} == 8'hB0) d = $urandom_range(0, 5);
      case ($urandom_range(0, 3))
        0:       cyc();
        1:       apb_rd_nc(a);
        default: apb_wr(a, d);
      endcase
    end
    repeat (4) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
